pucch_alpha_scheduler: RTL and testbench
========================================

Name: pucch_alpha_scheduler

Overview:
Per-slot sequencer for the 12-point cyclic-shift alpha generator used by PUCCH formats 0/1 and PUCCH DMRS. On a slot request it latches and validates the configuration, starts the generator, and waits for the generator to report ready. It then pulls one alpha per OFDM symbol, discards symbols before the allocation start, and streams the in-allocation alphas to the sequence/DMRS mapper over a valid/ready handshake.

Parameters:
N_SLOT_SYMB, 14, symbols per slot (normal CP); the allocation-range check uses this value.
READY_TIMEOUT, 4096, maximum cycles to wait for generator ready after start.
VALID_TIMEOUT, 64, maximum cycles to wait for generator valid after each get.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_slot_req  in  1  single-cycle request; samples all i_cfg_* inputs
i_cfg_nslot  in  8  slot number, 0..159
i_cfg_nid  in  10  scrambling identity
i_cfg_m0  in  4  initial cyclic shift, 0..11
i_cfg_mcs  in  4  sequence cyclic shift, 0..11
i_cfg_start_sym  in  4  first PUCCH symbol, 0..13
i_cfg_nrof_sym  in  4  number of PUCCH symbols, 1..14
o_gen_start  out  1  single-cycle start pulse to the generator
o_gen_get  out  1  single-cycle get pulse to the generator
o_gen_m0 / o_gen_mcs  out  4 each  latched m0 / mcs
o_gen_nslot  out  8  latched nslot
o_gen_nid  out  10  latched nid
i_gen_can_get  in  1  generator ready to serve gets
i_gen_alpha  in  5  generator alpha, 0..11
i_gen_valid  in  1  generator alpha valid; one cycle per get
o_alpha  out  4  alpha for the current symbol
o_sym_idx  out  4  symbol index within the slot
o_alpha_valid  out  1  output valid
i_alpha_ready  in  1  downstream ready
o_last  out  1  qualifies the final symbol of the allocation
o_busy  out  1  high whenever the FSM is not in IDLE
o_done  out  1  single-cycle pulse on normal completion
o_err  out  1  single-cycle pulse on a config or timeout error
o_err_code  out  2  1 = config, 2 = ready timeout, 3 = valid timeout; holds until the next error

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; latched config and counters cleared. A reset mid-slot abandons the slot and drops any pending output.
- FSM states: IDLE, START, WAIT_RDY, ISSUE, WAIT_VAL, OUTPUT, DONE.
- IDLE, on i_slot_req: latch the configuration. The config is invalid if any of the following hold:
  - m0 > 11
  - mcs > 11
  - nslot > 159
  - nrof_sym == 0
  - start_sym + nrof_sym > N_SLOT_SYMB (computed at 5 bits)
- Invalid config: o_err = 1 with code 1 in the next cycle; FSM stays in IDLE; the generator is not started.
- Valid config: go to START. The o_gen_* config outputs are driven from the latch and stay stable until the next accepted request.
- START: o_gen_start = 1 for exactly one cycle; symbol counter sym = 0; go to WAIT_RDY.
- WAIT_RDY: wait for i_gen_can_get, then go to ISSUE. If the wait exceeds READY_TIMEOUT cycles, raise an error with code 2 and go to IDLE.
- ISSUE: o_gen_get = 1 for one cycle; go to WAIT_VAL. At most one get is ever outstanding.
- WAIT_VAL: on i_gen_valid, handle the returned alpha:
  - sym < start_sym: discard it; sym++; go to ISSUE.
  - otherwise: register o_alpha = i_gen_alpha[3:0], o_sym_idx = sym, o_last = (sym == start_sym + nrof_sym - 1); go to OUTPUT.
  - No i_gen_valid within VALID_TIMEOUT cycles: error with code 3; go to IDLE.
- OUTPUT: hold o_alpha_valid and its data stable until i_alpha_ready. On the transfer cycle:
  - o_last set: go to DONE.
  - otherwise: sym++ and go to ISSUE. The next get is issued the cycle after the transfer.
- DONE: o_done = 1 for one cycle; go to IDLE.
- i_slot_req outside IDLE is ignored; no side effect.
- i_gen_valid outside WAIT_VAL is ignored.
- An i_gen_alpha value of 12 or more is passed through truncated to 4 bits; no check is made.
- Total gets per slot = start_sym + nrof_sym (never more than 14).
- Throughput with an immediately ready downstream: one symbol per (gen valid latency + 2) cycles.
- The minimum gap from DONE to the next accepted request is 1 cycle (i_slot_req is accepted in IDLE).

Test Plan:
- Generator model: can_get rises 20 cycles after start; valid comes 2 cycles after each get with alpha = (sym*5) mod 12. Request start_sym = 0, nrof = 14, ready tied to 1 → 14 outputs, sym 0..13, alphas 0,5,10,3,8,1,6,11,4,9,2,7,0,5; o_last only on sym 13; one o_done; exactly 14 gets.
- start_sym = 10, nrof = 4 → 14 gets issued; the first 10 alphas are discarded; outputs sym 10..13 with alphas 2,7,0,5; o_last on sym 13.
- Config errors: m0 = 12 → o_err with code 1 and no o_gen_start. Separately, start_sym = 12 with nrof = 3 → code 1. Separately, nrof = 0 → code 1.
- Backpressure: i_alpha_ready low for 7 cycles on sym 3 → o_alpha and o_sym_idx held stable; no get issued during the stall; the sequence completes correctly afterwards.
- Generator never asserts can_get → o_err with code 2 exactly READY_TIMEOUT cycles after WAIT_RDY is entered. Generator drops the valid for the 5th get → code 3 after VALID_TIMEOUT cycles. Both cases leave o_busy = 0.
- Second i_slot_req while busy is ignored. rst asserted during OUTPUT → all outputs 0 immediately (asynchronous); a fresh request after reset completes normally.

Source files
------------

// File: rtl/pucch_alpha_scheduler.sv
// ---------------------------------------------------------------------------
// pucch_alpha_scheduler
//
// Purpose: per-slot sequencer for the 12-point cyclic-shift alpha generator
// (PUCCH formats 0/1 and PUCCH DMRS). A slot request latches and validates
// the configuration and starts the generator. The block then waits for the
// generator to report ready and pulls one alpha per OFDM symbol. Symbols
// before the allocation start are discarded. In-allocation alphas are
// streamed downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_slot_req         one-cycle request, samples i_cfg_*
//   i_cfg_*            slot config (nslot, nid, m0, mcs, start_sym, nrof_sym)
//   o_gen_start/get    one-cycle pulses to the generator
//   o_gen_m0/mcs/nslot/nid   latched config driven to the generator
//   i_gen_can_get      generator ready to serve gets
//   i_gen_alpha/valid  generator result, one valid cycle per get
//   o_alpha/o_sym_idx/o_last/o_alpha_valid, i_alpha_ready   output stream
//   o_busy, o_done, o_err, o_err_code   status
// ---------------------------------------------------------------------------
module pucch_alpha_scheduler #(
   parameter int N_SLOT_SYMB   = 14,
   parameter int READY_TIMEOUT = 4096,
   parameter int VALID_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_slot_req,
   input  logic [7:0] i_cfg_nslot,
   input  logic [9:0] i_cfg_nid,
   input  logic [3:0] i_cfg_m0,
   input  logic [3:0] i_cfg_mcs,
   input  logic [3:0] i_cfg_start_sym,
   input  logic [3:0] i_cfg_nrof_sym,
   output logic       o_gen_start,
   output logic       o_gen_get,
   output logic [3:0] o_gen_m0,
   output logic [3:0] o_gen_mcs,
   output logic [7:0] o_gen_nslot,
   output logic [9:0] o_gen_nid,
   input  logic       i_gen_can_get,
   input  logic [4:0] i_gen_alpha,
   input  logic       i_gen_valid,
   output logic [3:0] o_alpha,
   output logic [3:0] o_sym_idx,
   output logic       o_alpha_valid,
   input  logic       i_alpha_ready,
   output logic       o_last,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err,
   output logic [1:0] o_err_code
);

   // One timeout counter is shared by WAIT_RDY and WAIT_VAL; it is sized
   // for the larger of the two limits.
   localparam int TMO_MAX = (READY_TIMEOUT > VALID_TIMEOUT) ? READY_TIMEOUT : VALID_TIMEOUT;
   localparam int TW      = $clog2(TMO_MAX) + 1;
   localparam logic [TW-1:0] RDY_LIM = TW'(READY_TIMEOUT - 1);
   localparam logic [TW-1:0] VAL_LIM = TW'(VALID_TIMEOUT - 1);
   localparam logic [4:0]    NSYM    = 5'(N_SLOT_SYMB);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT_RDY, S_ISSUE, S_WAIT_VAL, S_OUTPUT, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    nslot_q, nslot_d;
   logic [9:0]    nid_q, nid_d;
   logic [3:0]    m0_q, m0_d, mcs_q, mcs_d;
   logic [3:0]    start_q, start_d, nrof_q, nrof_d;
   logic [3:0]    sym_q, sym_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [3:0]    alpha_q, alpha_d, idx_q, idx_d;
   logic          last_q, last_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;

   logic [4:0]    cfg_sum;
   logic          cfg_bad;
   logic [4:0]    last_sym;

   // Alpha values of 12 or more are passed through truncated; bit 4 is dropped.
   logic          unused_alpha_msb;
   assign unused_alpha_msb = i_gen_alpha[4];

   // The range check is done at 5 bits so start_sym + nrof_sym cannot wrap.
   assign cfg_sum  = {1'b0, i_cfg_start_sym} + {1'b0, i_cfg_nrof_sym};
   assign cfg_bad  = (i_cfg_m0 > 4'd11) || (i_cfg_mcs > 4'd11) ||
                     (i_cfg_nslot > 8'd159) || (i_cfg_nrof_sym == 4'd0) ||
                     (cfg_sum > NSYM);
   assign last_sym = {1'b0, start_q} + {1'b0, nrof_q} - 5'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         nslot_q <= '0;
         nid_q   <= '0;
         m0_q    <= '0;
         mcs_q   <= '0;
         start_q <= '0;
         nrof_q  <= '0;
         sym_q   <= '0;
         tmo_q   <= '0;
         alpha_q <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         nslot_q <= nslot_d;
         nid_q   <= nid_d;
         m0_q    <= m0_d;
         mcs_q   <= mcs_d;
         start_q <= start_d;
         nrof_q  <= nrof_d;
         sym_q   <= sym_d;
         tmo_q   <= tmo_d;
         alpha_q <= alpha_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      nslot_d = nslot_q;
      nid_d   = nid_q;
      m0_d    = m0_q;
      mcs_d   = mcs_q;
      start_d = start_q;
      nrof_d  = nrof_q;
      sym_d   = sym_q;
      tmo_d   = tmo_q;
      alpha_d = alpha_q;
      idx_d   = idx_q;
      last_d  = last_q;
      err_d   = 1'b0;
      code_d  = code_q;
      case (state_q)
         S_IDLE: begin
            if (i_slot_req) begin
               if (cfg_bad) begin
                  err_d  = 1'b1;
                  code_d = 2'd1;
               end else begin
                  // Only accepted requests update the latch, so the
                  // generator config stays stable across rejected ones.
                  nslot_d = i_cfg_nslot;
                  nid_d   = i_cfg_nid;
                  m0_d    = i_cfg_m0;
                  mcs_d   = i_cfg_mcs;
                  start_d = i_cfg_start_sym;
                  nrof_d  = i_cfg_nrof_sym;
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            sym_d   = '0;
            tmo_d   = '0;
            state_d = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (i_gen_can_get) begin
               state_d = S_ISSUE;
            end else if (tmo_q == RDY_LIM) begin
               err_d   = 1'b1;
               code_d  = 2'd2;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_ISSUE: begin
            tmo_d   = '0;
            state_d = S_WAIT_VAL;
         end
         S_WAIT_VAL: begin
            if (i_gen_valid) begin
               if (sym_q < start_q) begin
                  sym_d   = sym_q + 4'd1;
                  state_d = S_ISSUE;
               end else begin
                  alpha_d = i_gen_alpha[3:0];
                  idx_d   = sym_q;
                  last_d  = ({1'b0, sym_q} == last_sym);
                  state_d = S_OUTPUT;
               end
            end else if (tmo_q == VAL_LIM) begin
               err_d   = 1'b1;
               code_d  = 2'd3;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_OUTPUT: begin
            if (i_alpha_ready) begin
               if (last_q) begin
                  state_d = S_DONE;
               end else begin
                  sym_d   = sym_q + 4'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pulses and valid are decoded from the state, so an asynchronous reset
   // clears them immediately.
   assign o_gen_start   = (state_q == S_START);
   assign o_gen_get     = (state_q == S_ISSUE);
   assign o_alpha_valid = (state_q == S_OUTPUT);
   assign o_done        = (state_q == S_DONE);
   assign o_busy        = (state_q != S_IDLE);
   assign o_gen_m0      = m0_q;
   assign o_gen_mcs     = mcs_q;
   assign o_gen_nslot   = nslot_q;
   assign o_gen_nid     = nid_q;
   assign o_alpha       = alpha_q;
   assign o_sym_idx     = idx_q;
   assign o_last        = last_q;
   assign o_err         = err_q;
   assign o_err_code    = code_q;

endmodule

// File: tb/tb_pucch_alpha_scheduler.sv
module tb_pucch_alpha_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_slot_req;
   logic [7:0] i_cfg_nslot;
   logic [9:0] i_cfg_nid;
   logic [3:0] i_cfg_m0, i_cfg_mcs, i_cfg_start_sym, i_cfg_nrof_sym;
   logic       o_gen_start, o_gen_get;
   logic [3:0] o_gen_m0, o_gen_mcs;
   logic [7:0] o_gen_nslot;
   logic [9:0] o_gen_nid;
   logic       i_gen_can_get;
   logic [4:0] i_gen_alpha;
   logic       i_gen_valid;
   logic [3:0] o_alpha, o_sym_idx;
   logic       o_alpha_valid, i_alpha_ready, o_last, o_busy, o_done, o_err;
   logic [1:0] o_err_code;

   int errors = 0;
   int checks = 0;

   pucch_alpha_scheduler dut (
      .clk(clk), .rst(rst), .i_slot_req(i_slot_req),
      .i_cfg_nslot(i_cfg_nslot), .i_cfg_nid(i_cfg_nid), .i_cfg_m0(i_cfg_m0),
      .i_cfg_mcs(i_cfg_mcs), .i_cfg_start_sym(i_cfg_start_sym),
      .i_cfg_nrof_sym(i_cfg_nrof_sym),
      .o_gen_start(o_gen_start), .o_gen_get(o_gen_get), .o_gen_m0(o_gen_m0),
      .o_gen_mcs(o_gen_mcs), .o_gen_nslot(o_gen_nslot), .o_gen_nid(o_gen_nid),
      .i_gen_can_get(i_gen_can_get), .i_gen_alpha(i_gen_alpha),
      .i_gen_valid(i_gen_valid),
      .o_alpha(o_alpha), .o_sym_idx(o_sym_idx), .o_alpha_valid(o_alpha_valid),
      .i_alpha_ready(i_alpha_ready), .o_last(o_last), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code)
   );

   always #5 clk = ~clk;

   wire [42:0] all_out = {o_gen_start, o_gen_get, o_gen_m0, o_gen_mcs, o_gen_nslot,
                          o_gen_nid, o_alpha, o_sym_idx, o_alpha_valid, o_last,
                          o_busy, o_done, o_err, o_err_code};

   // Expected alpha for symbol s is (s*5) mod 12.
   int exp_a[14] = '{0, 5, 10, 3, 8, 1, 6, 11, 4, 9, 2, 7, 0, 5};

   // ---------------- generator model ----------------
   bit         never_ready = 1'b0;
   int         drop_idx = -1;
   int         g_rdy_cnt, g_n;
   bit         g_armed, g_p1;
   logic [4:0] g_p1_alpha;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         i_gen_can_get <= 1'b0;
         i_gen_valid   <= 1'b0;
         i_gen_alpha   <= 5'd0;
         g_armed       <= 1'b0;
         g_n           <= 0;
         g_p1          <= 1'b0;
         g_p1_alpha    <= 5'd0;
         g_rdy_cnt     <= 0;
      end else begin
         i_gen_valid <= g_p1;
         i_gen_alpha <= g_p1 ? g_p1_alpha : 5'd0;
         g_p1        <= 1'b0;
         if (o_gen_get) begin
            g_p1       <= (g_n != drop_idx);
            g_p1_alpha <= 5'((g_n * 5) % 12);
            g_n        <= g_n + 1;
         end
         if (o_gen_start) begin
            g_armed       <= 1'b1;
            g_rdy_cnt     <= 0;
            g_n           <= 0;
            i_gen_can_get <= 1'b0;
         end else if (g_armed && !never_ready) begin
            g_rdy_cnt <= g_rdy_cnt + 1;
            if (g_rdy_cnt == 18) i_gen_can_get <= 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   int out_a[$], out_s[$], out_l[$];
   int get_cnt = 0, start_cnt = 0, done_cnt = 0;

   always @(negedge clk) begin
      if (o_gen_get)   get_cnt++;
      if (o_gen_start) start_cnt++;
      if (o_done)      done_cnt++;
      if (o_alpha_valid && i_alpha_ready) begin
         out_a.push_back(int'(o_alpha));
         out_s.push_back(int'(o_sym_idx));
         out_l.push_back(int'(o_last));
         $display("xfer: sym=%0d alpha=%0d last=%0d", o_sym_idx, o_alpha, o_last);
      end
   end

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [7:0] ns, input logic [9:0] nid, input logic [3:0] m0,
                      input logic [3:0] mcs, input logic [3:0] st, input logic [3:0] nr);
      i_cfg_nslot = ns; i_cfg_nid = nid; i_cfg_m0 = m0; i_cfg_mcs = mcs;
      i_cfg_start_sym = st; i_cfg_nrof_sym = nr;
      i_slot_req = 1'b1;
      cyc(1);
      i_slot_req = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (o_done) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      cyc(2);
      checks++;
      if (all_out !== 43'd0) begin
         errors++; $display("FAIL reset_held: outputs=%h required 0", all_out);
      end
      rst = 1'b0;
      cyc(2);
      checks++;
      if (all_out !== 43'd0) begin
         errors++; $display("FAIL reset_idle: outputs=%h required 0", all_out);
      end
   endtask

   task automatic test_full_slot;
      int base, g0, d0, s0; bit ok;
      base = out_a.size(); g0 = get_cnt; d0 = done_cnt; s0 = start_cnt;
      req(8'd159, 10'd1023, 4'd3, 4'd7, 4'd0, 4'd14);
      checks++;
      if ({o_gen_nslot, o_gen_nid, o_gen_m0, o_gen_mcs} !== {8'd159, 10'd1023, 4'd3, 4'd7}) begin
         errors++; $display("FAIL full_cfg_latch: nslot=%0d nid=%0d m0=%0d mcs=%0d required 159 1023 3 7",
                            o_gen_nslot, o_gen_nid, o_gen_m0, o_gen_mcs);
      end
      wait_done(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_done_timeout: got no o_done required o_done"); end
      cyc(1);
      checks++;
      if (out_a.size() - base !== 14) begin
         errors++; $display("FAIL full_count: got %0d outputs required 14", out_a.size() - base);
      end
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (qget(out_a, base+i) !== exp_a[i] || qget(out_s, base+i) !== i ||
             qget(out_l, base+i) !== int'(i == 13)) begin
            errors++;
            $display("FAIL full_sym%0d: got alpha=%0d sym=%0d last=%0d required alpha=%0d sym=%0d last=%0d",
                     i, qget(out_a, base+i), qget(out_s, base+i), qget(out_l, base+i),
                     exp_a[i], i, int'(i == 13));
         end
      end
      checks++;
      if (get_cnt - g0 !== 14 || done_cnt - d0 !== 1 || start_cnt - s0 !== 1 || o_busy !== 1'b0) begin
         errors++; $display("FAIL full_counts: gets=%0d dones=%0d starts=%0d busy=%0d required 14 1 1 0",
                            get_cnt - g0, done_cnt - d0, start_cnt - s0, o_busy);
      end
   endtask

   task automatic test_partial;
      int base, g0; bit ok;
      base = out_a.size(); g0 = get_cnt;
      req(8'd5, 10'd77, 4'd1, 4'd2, 4'd10, 4'd4);
      wait_done(400, ok);
      cyc(1);
      checks++;
      if (!ok || out_a.size() - base !== 4 || get_cnt - g0 !== 14) begin
         errors++; $display("FAIL partial_counts: done=%0d outputs=%0d gets=%0d required 1 4 14",
                            ok, out_a.size() - base, get_cnt - g0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (qget(out_a, base+i) !== exp_a[10+i] || qget(out_s, base+i) !== 10+i ||
             qget(out_l, base+i) !== int'(i == 3)) begin
            errors++;
            $display("FAIL partial_sym%0d: got alpha=%0d sym=%0d last=%0d required alpha=%0d sym=%0d last=%0d",
                     10+i, qget(out_a, base+i), qget(out_s, base+i), qget(out_l, base+i),
                     exp_a[10+i], 10+i, int'(i == 3));
         end
      end
   endtask

   task automatic test_cfg_errors;
      int m0_t[3] = '{12, 0, 0};
      int st_t[3] = '{0, 12, 0};
      int nr_t[3] = '{14, 3, 0};
      int s0;
      for (int k = 0; k < 3; k++) begin
         s0 = start_cnt;
         req(8'd3, 10'd9, 4'(m0_t[k]), 4'd1, 4'(st_t[k]), 4'(nr_t[k]));
         checks++;
         if (o_err !== 1'b1 || o_err_code !== 2'd1) begin
            errors++; $display("FAIL cfg_err%0d: err=%0d code=%0d required 1 1", k, o_err, o_err_code);
         end
         cyc(3);
         checks++;
         if (start_cnt !== s0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            errors++; $display("FAIL cfg_nostart%0d: starts=%0d busy=%0d err=%0d required %0d 0 0",
                               k, start_cnt, o_busy, o_err, s0);
         end
      end
   endtask

   task automatic test_backpressure;
      int base, g0, gs; bit ok; bit found;
      base = out_a.size(); g0 = get_cnt; found = 1'b0;
      req(8'd0, 10'd0, 4'd0, 4'd0, 4'd0, 4'd14);
      for (int i = 0; i < 400; i++) begin
         if (o_alpha_valid && o_sym_idx == 4'd3) begin
            i_alpha_ready = 1'b0;
            found = 1'b1;
            break;
         end
         cyc(1);
      end
      checks++;
      if (!found) begin errors++; $display("FAIL bp_reach_sym3: got no valid on sym 3 required valid"); end
      gs = get_cnt;
      for (int c = 0; c < 7; c++) begin
         checks++;
         if (o_alpha_valid !== 1'b1 || o_alpha !== 4'd3 || o_sym_idx !== 4'd3) begin
            errors++; $display("FAIL bp_hold_c%0d: valid=%0d alpha=%0d sym=%0d required 1 3 3",
                               c, o_alpha_valid, o_alpha, o_sym_idx);
         end
         cyc(1);
      end
      checks++;
      if (get_cnt !== gs) begin
         errors++; $display("FAIL bp_no_get: got %0d gets during stall required 0", get_cnt - gs);
      end
      i_alpha_ready = 1'b1;
      wait_done(400, ok);
      cyc(1);
      checks++;
      if (!ok || out_a.size() - base !== 14 || get_cnt - g0 !== 14) begin
         errors++; $display("FAIL bp_counts: done=%0d outputs=%0d gets=%0d required 1 14 14",
                            ok, out_a.size() - base, get_cnt - g0);
      end
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (qget(out_a, base+i) !== exp_a[i] || qget(out_s, base+i) !== i) begin
            errors++; $display("FAIL bp_sym%0d: got alpha=%0d sym=%0d required alpha=%0d sym=%0d",
                               i, qget(out_a, base+i), qget(out_s, base+i), exp_a[i], i);
         end
      end
   endtask

   task automatic test_ready_timeout;
      int n;
      never_ready = 1'b1;
      req(8'd1, 10'd1, 4'd1, 4'd1, 4'd0, 4'd14);
      checks++;
      if (o_gen_start !== 1'b1) begin
         errors++; $display("FAIL rdy_start: o_gen_start=%0d required 1", o_gen_start);
      end
      n = 0;
      while (n < 5000 && o_err !== 1'b1) begin cyc(1); n++; end
      checks++;
      if (n !== 4097 || o_err_code !== 2'd2 || o_busy !== 1'b0) begin
         errors++; $display("FAIL rdy_timeout: cycles=%0d code=%0d busy=%0d required 4097 2 0",
                            n, o_err_code, o_busy);
      end
      never_ready = 1'b0;
      cyc(2);
   endtask

   task automatic test_valid_timeout;
      int k, n, base;
      base = out_a.size(); k = 0;
      drop_idx = 4;
      req(8'd2, 10'd2, 4'd2, 4'd2, 4'd0, 4'd14);
      for (int i = 0; i < 400; i++) begin
         if (o_gen_get) begin
            k++;
            if (k == 5) break;
         end
         cyc(1);
      end
      checks++;
      if (k !== 5) begin errors++; $display("FAIL val_fifth_get: got %0d gets required 5", k); end
      n = 0;
      while (n < 200 && o_err !== 1'b1) begin cyc(1); n++; end
      checks++;
      if (n !== 65 || o_err_code !== 2'd3 || o_busy !== 1'b0) begin
         errors++; $display("FAIL val_timeout: cycles=%0d code=%0d busy=%0d required 65 3 0",
                            n, o_err_code, o_busy);
      end
      checks++;
      if (out_a.size() - base !== 4) begin
         errors++; $display("FAIL val_outputs: got %0d outputs required 4", out_a.size() - base);
      end
      drop_idx = -1;
      cyc(2);
   endtask

   task automatic test_back_to_back;
      int base, s0; bit ok;
      base = out_a.size(); s0 = start_cnt;
      req(8'd10, 10'd10, 4'd2, 4'd4, 4'd10, 4'd4);
      cyc(5);
      req(8'd1, 10'd1, 4'd9, 4'd9, 4'd0, 4'd14);
      checks++;
      if (o_gen_m0 !== 4'd2 || o_gen_mcs !== 4'd4 || o_busy !== 1'b1) begin
         errors++; $display("FAIL b2b_ignore_cfg: m0=%0d mcs=%0d busy=%0d required 2 4 1",
                            o_gen_m0, o_gen_mcs, o_busy);
      end
      wait_done(400, ok);
      cyc(1);
      checks++;
      if (!ok || out_a.size() - base !== 4 || start_cnt - s0 !== 1) begin
         errors++; $display("FAIL b2b_first: done=%0d outputs=%0d starts=%0d required 1 4 1",
                            ok, out_a.size() - base, start_cnt - s0);
      end
      base = out_a.size();
      req(8'd11, 10'd11, 4'd0, 4'd0, 4'd13, 4'd1);
      checks++;
      if (o_gen_start !== 1'b1) begin
         errors++; $display("FAIL b2b_accept: o_gen_start=%0d required 1", o_gen_start);
      end
      wait_done(400, ok);
      cyc(1);
      checks++;
      if (!ok || out_a.size() - base !== 1 || qget(out_a, base) !== 5 ||
          qget(out_s, base) !== 13 || qget(out_l, base) !== 1) begin
         errors++; $display("FAIL b2b_second: done=%0d outputs=%0d alpha=%0d sym=%0d last=%0d required 1 1 5 13 1",
                            ok, out_a.size() - base, qget(out_a, base), qget(out_s, base), qget(out_l, base));
      end
   endtask

   task automatic test_reset_mid;
      int base, g0; bit ok; bit found;
      found = 1'b0;
      i_alpha_ready = 1'b0;
      req(8'd20, 10'd20, 4'd5, 4'd6, 4'd0, 4'd14);
      for (int i = 0; i < 200; i++) begin
         if (o_alpha_valid) begin found = 1'b1; break; end
         cyc(1);
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rstmid_reach: got no output valid required valid"); end
      rst = 1'b1;
      #1;
      checks++;
      if (all_out !== 43'd0) begin
         errors++; $display("FAIL rstmid_async: outputs=%h required 0", all_out);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      i_alpha_ready = 1'b1;
      cyc(1);
      base = out_a.size(); g0 = get_cnt;
      req(8'd21, 10'd21, 4'd1, 4'd1, 4'd12, 4'd2);
      wait_done(400, ok);
      cyc(1);
      checks++;
      if (!ok || out_a.size() - base !== 2 || get_cnt - g0 !== 14 ||
          qget(out_a, base) !== 0 || qget(out_s, base) !== 12 || qget(out_l, base) !== 0 ||
          qget(out_a, base+1) !== 5 || qget(out_s, base+1) !== 13 || qget(out_l, base+1) !== 1) begin
         errors++; $display("FAIL rstmid_fresh: done=%0d outputs=%0d gets=%0d a0=%0d s0=%0d a1=%0d s1=%0d l1=%0d required 1 2 14 0 12 5 13 1",
                            ok, out_a.size() - base, get_cnt - g0, qget(out_a, base), qget(out_s, base),
                            qget(out_a, base+1), qget(out_s, base+1), qget(out_l, base+1));
      end
   endtask

   initial begin
      rst = 1'b1;
      i_slot_req = 1'b0;
      i_cfg_nslot = '0; i_cfg_nid = '0; i_cfg_m0 = '0; i_cfg_mcs = '0;
      i_cfg_start_sym = '0; i_cfg_nrof_sym = '0;
      i_alpha_ready = 1'b1;
      test_reset;
      test_full_slot;
      test_partial;
      test_cfg_errors;
      test_backpressure;
      test_ready_timeout;
      test_valid_timeout;
      test_back_to_back;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
